// File: rtl/bus_trace_pkg.sv
// Shared types and constants for the bus trace recorder.
// The optional timestamp field is enabled with BUS_TRACE_TIMESTAMP_EN.
package bus_trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        POST,
        FULL,
        DUMP
    } trace_state_e;

    typedef enum logic [2:0] {
        SEG_HDR,
        SEG_CNT_HI,
        SEG_CNT_LO,
        SEG_REC,
        SEG_TRL
    } dump_seg_e;

    localparam logic [7:0] TRACE_HEADER  = 8'hA5;
    localparam logic [7:0] TRACE_TRAILER = 8'h5A;
    localparam int         TS_WIDTH      = 16;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Read data appears one cycle after rd_en_i and holds until the next read.
module trace_ram #(
    parameter int WIDTH  = 40,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Store one trace record.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; output holds between reads so the dump can prefetch.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_trace_recorder.sv
// Bus trace recorder: circular capture with pre/post trigger window and a
// framed byte dump (A5, count hi, count lo, records oldest first, 5A).
// Define BUS_TRACE_TIMESTAMP_EN to append a 16-bit timestamp to each record.
//
// state | meaning
// IDLE  | no capture running; previous capture retained
// PRE   | armed, storing samples, watching for trigger
// POST  | triggered, storing the post-trigger samples
// FULL  | capture window complete, waiting for dump or re-arm
// DUMP  | streaming the frame on out_valid/out_ready
module bus_trace_recorder
    import bus_trace_pkg::*;
#(
    parameter int BITWIDTH     = 32,
    parameter int CTRLWIDTH    = 8,
    parameter int DEPTH        = 32,
    parameter int POST_TRIGGER = 16
) (
    input  logic                 comm_clock,
    input  logic                 reset_n,
    input  logic                 sample_en,
    input  logic [BITWIDTH-1:0]  sample_addr,
    input  logic [CTRLWIDTH-1:0] sample_ctrl,
    input  logic                 arm,
    input  logic [BITWIDTH-1:0]  match_value,
    input  logic [BITWIDTH-1:0]  match_mask,
    input  logic                 force_trigger,
    input  logic                 dump_start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 armed,
    output logic                 triggered,
    output logic                 dump_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef BUS_TRACE_TIMESTAMP_EN
    localparam int TSW = TS_WIDTH;
`else
    localparam int TSW = 0;
`endif
    localparam int RW  = BITWIDTH + CTRLWIDTH + TSW;
    localparam int RB  = RW / 8;
    localparam int BIW = $clog2(RB);

    localparam logic [AW-1:0]  ONE_A     = AW'(1);
    localparam logic [CW-1:0]  ONE_C     = CW'(1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
    localparam logic [AW-1:0]  POST_INIT = AW'(POST_TRIGGER);
    localparam logic [BIW-1:0] ONE_B     = BIW'(1);
    localparam logic [BIW-1:0] LAST_B    = BIW'(RB - 1);

    trace_state_e   state_q, state_d;
    dump_seg_e      seg_q, seg_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  post_q, post_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic [BIW-1:0] bidx_q, bidx_d;
    logic [RW-1:0]  sh_q, sh_d;

    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [RW-1:0]  wr_rec;
    logic [RW-1:0]  rd_data;
    logic [AW-1:0]  oldest;
    logic [CW-1:0]  count_inc;
    logic [15:0]    count16;
    logic           hit;

`ifdef BUS_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running timestamp, stored alongside every sample.
    always_ff @(posedge comm_clock) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    assign wr_rec = {sample_addr, sample_ctrl, ts_q};
`else
    assign wr_rec = {sample_addr, sample_ctrl};
`endif

    assign hit       = ((sample_addr ^ match_value) & match_mask) == '0;
    assign oldest    = wr_ptr_q - count_q[AW-1:0];
    assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + ONE_C;
    assign count16   = 16'(count_q);

    trace_ram #(
        .WIDTH  (RW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk_i     (comm_clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_rec),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Capture/dump sequencing; the next record is read while the current
    // one is being shifted out so records follow back to back.
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        bidx_d   = bidx_q;
        sh_d     = sh_q;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = rd_ptr_q;

        case (state_q)
            IDLE, FULL: begin
                if (arm) begin
                    state_d  = PRE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else if (dump_start) begin
                    state_d  = DUMP;
                    seg_d    = SEG_HDR;
                    rd_en    = 1'b1;
                    rd_addr  = oldest;
                    rd_ptr_d = oldest + ONE_A;
                end
            end
            PRE: begin
                if (arm) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (sample_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        count_d  = count_inc;
                    end
                    if (force_trigger || (sample_en && hit)) begin
                        post_d  = POST_INIT;
                        state_d = (POST_TRIGGER == 0) ? FULL : POST;
                    end
                end
            end
            POST: begin
                if (arm) begin
                    state_d  = PRE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else if (sample_en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_A;
                    count_d  = count_inc;
                    post_d   = post_q - ONE_A;
                    if (post_q == ONE_A) begin
                        state_d = FULL;
                    end
                end
            end
            DUMP: begin
                if (out_ready) begin
                    case (seg_q)
                        SEG_HDR:    seg_d = SEG_CNT_HI;
                        SEG_CNT_HI: seg_d = SEG_CNT_LO;
                        SEG_CNT_LO: begin
                            if (count_q == '0) begin
                                seg_d = SEG_TRL;
                            end else begin
                                seg_d    = SEG_REC;
                                sh_d     = rd_data;
                                bidx_d   = '0;
                                rem_d    = count_q - ONE_C;
                                rd_en    = 1'b1;
                                rd_ptr_d = rd_ptr_q + ONE_A;
                            end
                        end
                        SEG_REC: begin
                            if (bidx_q == LAST_B) begin
                                if (rem_q == '0) begin
                                    seg_d = SEG_TRL;
                                end else begin
                                    sh_d     = rd_data;
                                    bidx_d   = '0;
                                    rem_d    = rem_q - ONE_C;
                                    rd_en    = 1'b1;
                                    rd_ptr_d = rd_ptr_q + ONE_A;
                                end
                            end else begin
                                sh_d   = {sh_q[RW-9:0], 8'h00};
                                bidx_d = bidx_q + ONE_B;
                            end
                        end
                        SEG_TRL: begin
                            state_d = IDLE;
                            seg_d   = SEG_HDR;
                        end
                        default: seg_d = SEG_HDR;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge comm_clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            seg_q    <= SEG_HDR;
            wr_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            rd_ptr_q <= '0;
            rem_q    <= '0;
            bidx_q   <= '0;
            sh_q     <= '0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            rd_ptr_q <= rd_ptr_d;
            rem_q    <= rem_d;
            bidx_q   <= bidx_d;
            sh_q     <= sh_d;
        end
    end

    // Output byte selection; zero whenever no dump is in progress.
    always_comb begin
        out_data = 8'h00;
        if (state_q == DUMP) begin
            case (seg_q)
                SEG_HDR:    out_data = TRACE_HEADER;
                SEG_CNT_HI: out_data = count16[15:8];
                SEG_CNT_LO: out_data = count16[7:0];
                SEG_REC:    out_data = sh_q[RW-1 -: 8];
                SEG_TRL:    out_data = TRACE_TRAILER;
                default:    out_data = 8'h00;
            endcase
        end
    end

    assign out_valid = (state_q == DUMP);
    assign dump_busy = (state_q == DUMP);
    assign armed     = (state_q == PRE);
    assign triggered = (state_q == POST) || (state_q == FULL);

endmodule

// File: tb/tb_bus_trace_recorder.sv
// Bench for bus_trace_recorder with BITWIDTH=32, CTRLWIDTH=8, DEPTH=8,
// POST_TRIGGER=4, no timestamp.
module tb_bus_trace_recorder;

    localparam int BW  = 32;
    localparam int CTW = 8;
    localparam int DP  = 8;
    localparam int PT  = 4;

    logic        comm_clock = 1'b0;
    logic        reset_n;
    logic        sample_en;
    logic [31:0] sample_addr;
    logic [7:0]  sample_ctrl;
    logic        arm;
    logic [31:0] match_value;
    logic [31:0] match_mask;
    logic        force_trigger;
    logic        dump_start;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        armed;
    logic        triggered;
    logic        dump_busy;

    always #5 comm_clock = ~comm_clock;

    bus_trace_recorder #(
        .BITWIDTH     (BW),
        .CTRLWIDTH    (CTW),
        .DEPTH        (DP),
        .POST_TRIGGER (PT)
    ) dut (
        .comm_clock    (comm_clock),
        .reset_n       (reset_n),
        .sample_en     (sample_en),
        .sample_addr   (sample_addr),
        .sample_ctrl   (sample_ctrl),
        .arm           (arm),
        .match_value   (match_value),
        .match_mask    (match_mask),
        .force_trigger (force_trigger),
        .dump_start    (dump_start),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .armed         (armed),
        .triggered     (triggered),
        .dump_busy     (dump_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of retained records plus capture phase
    // (0 idle, 1 waiting for trigger, 2 collecting post samples, 3 complete).
    logic [39:0] mq[$];
    int          mst   = 0;
    int          mleft = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  prev_q[$];

    typedef struct {
        bit          a;
        bit          en;
        logic [31:0] ad;
        bit          f;
        bit          ea;
        bit          et;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gotb(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] expb(input int i);
        if (i < exp_q.size()) return exp_q[i];
        return 8'hxx;
    endfunction

    task automatic model_push(input logic [39:0] r);
        mq.push_back(r);
        if (mq.size() > DP) void'(mq.pop_front());
    endtask

    task automatic step(input bit a, input bit en, input logic [31:0] ad, input bit f);
        bit hit;
        arm           = a;
        sample_en     = en;
        sample_addr   = ad;
        sample_ctrl   = ad[7:0];
        force_trigger = f;
        hit = en && ((ad & match_mask) == (match_value & match_mask));
        if (a) begin
            mq.delete();
            mst = 1;
        end else if (mst == 1) begin
            if (en) model_push({ad, ad[7:0]});
            if (f || hit) begin
                mleft = PT;
                mst   = (PT == 0) ? 3 : 2;
            end
        end else if (mst == 2 && en) begin
            model_push({ad, ad[7:0]});
            mleft--;
            if (mleft == 0) mst = 3;
        end
        @(posedge comm_clock);
        #1;
        arm           = 1'b0;
        sample_en     = 1'b0;
        force_trigger = 1'b0;
        dump_start    = 1'b0;
    endtask

    task automatic build_expected();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(mq.size() >> 8));
        exp_q.push_back(8'(mq.size()));
        foreach (mq[i]) begin
            for (int b = 4; b >= 0; b--) exp_q.push_back(mq[i][b*8 +: 8]);
        end
        exp_q.push_back(8'h5A);
    endtask

    task automatic compare_stream(input string name);
        int first = -1;
        int n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (first < 0 && gotb(i) !== expb(i)) first = i;
        end
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s stream: byte %0d got %0h want %0h (got %0d bytes, want %0d)",
                     name, first, gotb(first), expb(first), got_q.size(), exp_q.size());
        end
    endtask

    // mode 0: always ready; 1: 5-cycle stall after 4th byte with arm/sample
    // noise; 2: random ready.
    task automatic run_dump(input string name, input int mode);
        int         cyc = 0;
        int         first_valid = -1;
        int         stall_done = 0;
        bit         rdy;
        bit         v;
        bit         stalled = 1'b0;
        logic [7:0] d;
        logic [7:0] held = 8'h00;
        got_q.delete();
        dump_start = 1'b1;
        @(posedge comm_clock);
        #1;
        dump_start = 1'b0;
        check({name, " busy"}, 32'(dump_busy), 32'd1);
        while (got_q.size() < exp_q.size() && cyc < 2000) begin
            case (mode)
                1: begin
                    rdy = !(got_q.size() == 4 && stall_done < 5);
                    if (!rdy) stall_done++;
                end
                2: rdy = ($urandom_range(0, 2) != 0);
                default: rdy = 1'b1;
            endcase
            arm       = (mode == 1 && cyc == 3);
            sample_en = (mode == 1);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check({name, " stall data"}, 32'(out_data), 32'(held));
                check({name, " stall valid"}, 32'(out_valid), 32'd1);
            end
            out_ready = rdy;
            v = out_valid;
            d = out_data;
            @(posedge comm_clock);
            #1;
            if (v && rdy) got_q.push_back(d);
            stalled = v && !rdy;
            held    = d;
            cyc++;
        end
        out_ready = 1'b0;
        arm       = 1'b0;
        sample_en = 1'b0;
        check({name, " valid latency"}, 32'(first_valid >= 0 && first_valid <= 2), 32'd1);
        if (mode == 0) check({name, " cycles"}, 32'(cyc), 32'(exp_q.size()));
        check({name, " busy after"}, 32'(dump_busy), 32'd0);
        check({name, " valid after"}, 32'(out_valid), 32'd0);
        compare_stream(name);
        mst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs;
        reset_n       = 1'b0;
        sample_en     = 1'b0;
        sample_addr   = '0;
        sample_ctrl   = '0;
        arm           = 1'b0;
        match_value   = '0;
        match_mask    = '0;
        force_trigger = 1'b0;
        dump_start    = 1'b0;
        out_ready     = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_0012, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_1300, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h00FF_1100, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0011_1234, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_1200, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_0009, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_000A, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'h0000_1200, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 32'h0000_000D, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 32'h0000_000E, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge comm_clock);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'h00);
        check("rst armed", 32'(armed), 32'd0);
        check("rst triggered", 32'(triggered), 32'd0);
        check("rst dump_busy", 32'(dump_busy), 32'd0);
        reset_n = 1'b1;

        // Empty buffer after reset.
        exp_q = '{8'hA5, 8'h00, 8'h00, 8'h5A};
        run_dump("empty", 0);

        // Exact match on address 10.
        match_value = 32'd10;
        match_mask  = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 32'(i), 1'b0);
            check($sformatf("match armed %0d", i), 32'(armed), 32'(i < 10));
            check($sformatf("match trig %0d", i), 32'(triggered), 32'(i >= 10));
        end
        build_expected();
        run_dump("match", 0);
        check("match count lo", 32'(gotb(2)), 32'h08);
        check("match first addr", 32'(gotb(6)), 32'h07);
        check("match first ctrl", 32'(gotb(7)), 32'h07);
        check("match last addr", 32'(gotb(41)), 32'h0E);
        check("match trailer", 32'(gotb(43)), 32'h5A);

        // Forced trigger with partial buffer, dump ignored in POST.
        match_value = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b1, 32'h101, 1'b0);
        check("force pre armed", 32'(armed), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("force trig", 32'(triggered), 32'd1);
        check("force armed", 32'(armed), 32'd0);
        dump_start = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("dump in post ignored", 32'(dump_busy), 32'd0);
        for (int i = 2; i < 6; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
        check("force full trig", 32'(triggered), 32'd1);
        build_expected();
        run_dump("force stall", 1);
        check("force count lo", 32'(gotb(2)), 32'h06);
        check("force first addr", 32'(gotb(5)), 32'h01);
        check("force last addr", 32'(gotb(31)), 32'h05);
        check("force trailer", 32'(gotb(33)), 32'h5A);
        prev_q = got_q;
        run_dump("force repeat", 0);
        diffs = (prev_q.size() == got_q.size()) ? 0 : 1;
        for (int i = 0; i < prev_q.size() && i < got_q.size(); i++) begin
            if (prev_q[i] !== got_q[i]) diffs++;
        end
        check("stall vs nostall", 32'(diffs), 32'd0);

        // Reset mid-dump.
        dump_start = 1'b1;
        @(posedge comm_clock);
        #1;
        dump_start = 1'b0;
        out_ready  = 1'b1;
        repeat (3) begin
            @(posedge comm_clock);
            #1;
        end
        check("abort pre busy", 32'(dump_busy), 32'd1);
        reset_n = 1'b0;
        @(posedge comm_clock);
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_data", 32'(out_data), 32'h00);
        check("abort armed", 32'(armed), 32'd0);
        check("abort triggered", 32'(triggered), 32'd0);
        check("abort dump_busy", 32'(dump_busy), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b0;
        mq.delete();
        mst = 0;
        exp_q = '{8'hA5, 8'h00, 8'h00, 8'h5A};
        run_dump("empty after abort", 0);

        // Masked match, table driven.
        match_value = 32'h0000_1200;
        match_mask  = 32'h0000_FF00;
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].a, tbl[i].en, tbl[i].ad, tbl[i].f);
            check($sformatf("tbl%0d armed", i), 32'(armed), 32'(tbl[i].ea));
            check($sformatf("tbl%0d trig", i), 32'(triggered), 32'(tbl[i].et));
        end
        build_expected();
        run_dump("masked", 0);
        check("masked count lo", 32'(gotb(2)), 32'h05);

        // Random captures against the model.
        for (int it = 0; it < 6; it++) begin
            int n;
            match_value = $urandom;
            match_mask  = $urandom & 32'h0000_001F;
            step(1'b1, 1'b0, 32'd0, 1'b0);
            n = $urandom_range(3, 30);
            for (int c = 0; c < n; c++) begin
                step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                     $urandom, $urandom_range(0, 25) == 0);
                check($sformatf("rnd%0d armed", it), 32'(armed), 32'(mst == 1));
                check($sformatf("rnd%0d trig", it), 32'(triggered), 32'(mst >= 2));
            end
            for (int k = 0; k < 20 && (mst == 1 || mst == 2); k++) begin
                step(1'b0, 1'b1, $urandom, 1'b1);
            end
            check($sformatf("rnd%0d full", it), 32'(triggered), 32'd1);
            build_expected();
            run_dump($sformatf("rnd%0d", it), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
